excp_commit_ctrl: RTL and testbench
===================================

# excp_commit_ctrl

Sequences exception, interrupt and ERTN commit for the CSR file, sitting at the tail of the WB stage. It selects the highest-priority commit event and flushes the pipeline. Optionally, it waits for outstanding data-side memory transactions to drain. It then pulses the CSR file's exception/ERTN inputs for exactly one cycle and issues a single redirect to preIF.

## Interface
- OUTS_W, 4, width of outstanding data-transaction counter (max 2^OUTS_W-1 in flight)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  WB holds a valid instruction
- wb_pc  in  32  PC of WB instruction
- wb_excp  in  1  synchronous exception on WB instruction
- wb_tlbr  in  1  exception is TLB refill (ignored unless wb_excp)
- wb_ecode / wb_esubcode  in  6 / 9  exception codes
- wb_badv_valid / wb_badv  in  1 / 32  address-related exception and faulting address
- wb_ertn  in  1  WB instruction is ERTN
- has_int  in  1  pending enabled interrupt from CSR file
- mem_issue / mem_done  in  1 / 1  data request accepted / data response completed
- eentry_in, tlbrentry_in, era_in  in  32 each  CSR entry/return addresses
- wb_ready  out  1  WB may retire; high only in IDLE
- flush  out  1  squash all stages younger than WB
- csr_excp, csr_excp_tlbrefill, csr_ertn  out  1 each  one-cycle commit pulses
- csr_era, csr_badv_addr  out  32 each;  csr_code  out  6;  csr_subcode  out  9;  csr_excpAboutAddr  out  1
- redirect_valid  out  1;  redirect_pc  out  32

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- Trigger in IDLE: wb_valid & (has_int | wb_excp | wb_ertn).
- Priority: has_int > wb_excp > wb_ertn.
- Latched on trigger:
  - kind: INT / EXC / ERTN.
  - era ← wb_pc.
  - For INT: code = 6'h0, subcode = 0, badv flag = 0.
  - For EXC: code, subcode, tlbr and badv taken from WB inputs.
- IDLE → DRAIN on trigger. DRAIN → COMMIT when the counter is 0, evaluated on the registered count. COMMIT → REDIRECT. REDIRECT → IDLE.
- COMMIT:
  - kind INT/EXC: csr_excp = 1; csr_excp_tlbrefill = latched tlbr; csr_excpAboutAddr = latched badv flag.
  - kind ERTN: csr_ertn = 1.
  - All pulses are 0 in every other state.
- csr_era, csr_code, csr_subcode and csr_badv_addr hold the latched values continuously.
- REDIRECT:
  - redirect_valid = 1.
  - redirect_pc = tlbrentry_in if latched tlbr, else eentry_in for INT/EXC, else era_in for ERTN.
  - In every other state, redirect_valid = 0 and redirect_pc = 0.
- flush = (state != IDLE); wb_ready = (state == IDLE).
- Outstanding counter:
  - mem_issue only → +1; mem_done only → −1; both → unchanged.
  - mem_done at 0 is ignored; mem_issue at max is ignored (the upstream must never issue beyond max).
  - The counter runs in every state.
- A trigger while wb_valid=0 is ignored.
- Events outside IDLE are not sampled; WB is stalled.

## Timing
- Reset values: state IDLE, counter 0, all latched fields 0. Outputs after reset: flush=0, wb_ready=1, all pulses 0, redirect_valid=0, redirect_pc=0, csr_* = 0.
- Trigger in cycle T with counter 0 at T+1:
  - flush high T+1..T+3.
  - csr_excp/csr_ertn high in T+2.
  - redirect_valid high in T+3.
  - IDLE in T+4.
- With N outstanding: COMMIT occurs the cycle after the counter is first observed 0 in DRAIN.
- Redirect follows commit by exactly one cycle, so era_in and eentry_in reflect the committed CSR state.
- Reset asserted mid-sequence: the next cycle is IDLE, counter 0, no pulse and no redirect emitted.

## Configuration
- EXCP_DRAIN_EN defined:
  - The DRAIN state and outstanding counter are present, as described above.
- EXCP_DRAIN_EN undefined:
  - No counter; mem_issue and mem_done are ignored.
  - IDLE → COMMIT directly on trigger, giving pulse at T+1, redirect at T+2, IDLE at T+3.

## Test plan
- wb_valid=1, wb_excp=1, wb_ecode=6'hB, wb_pc=0x1c000100, eentry_in=0x1c008000, counter 0 → csr_excp at T+2 with csr_code=0xB, csr_era=0x1c000100; redirect_pc=0x1c008000 at T+3.
- has_int=1 together with wb_ertn=1 → INT wins: csr_excp pulse, csr_code=0, no csr_ertn.
- wb_ertn=1, era_in=0x1c000204 → csr_ertn single pulse; redirect_pc=0x1c000204.
- Three mem_issue, then trigger, then mem_done spaced 5 cycles apart → flush held throughout; csr_excp one cycle after the third mem_done registers.
- wb_excp with wb_tlbr=1, tlbrentry_in=0x1c00f000 → csr_excp_tlbrefill=1 at commit; redirect_pc=0x1c00f000.
- Reset asserted during DRAIN → no pulse or redirect; wb_ready=1 and flush=0 the next cycle; mem_issue+mem_done in the same cycle leaves the counter unchanged.

Source files
------------

// File: rtl/excp_commit_ctrl.sv
// excp_commit_ctrl: sequences INT/EXC/ERTN commit, pipeline flush and redirect.
// Define EXCP_DRAIN_EN to wait for outstanding data transactions before commit.
module excp_commit_ctrl #(
  parameter int OUTS_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_excp,
  input  logic        wb_tlbr,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_badv_valid,
  input  logic [31:0] wb_badv,
  input  logic        wb_ertn,
  input  logic        has_int,
  input  logic        mem_issue,
  input  logic        mem_done,
  input  logic [31:0] eentry_in,
  input  logic [31:0] tlbrentry_in,
  input  logic [31:0] era_in,
  output logic        wb_ready,
  output logic        flush,
  output logic        csr_excp,
  output logic        csr_excp_tlbrefill,
  output logic        csr_ertn,
  output logic [31:0] csr_era,
  output logic [31:0] csr_badv_addr,
  output logic [5:0]  csr_code,
  output logic [8:0]  csr_subcode,
  output logic        csr_excpAboutAddr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    K_INT,
    K_EXC,
    K_ERTN
  } kind_t;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_trig_state;
  kind_t       r_kind;
  logic [31:0] r_era;
  logic [5:0]  r_code;
  logic [8:0]  r_subcode;
  logic        r_tlbr;
  logic        r_badv_flag;
  logic [31:0] r_badv;
  logic        w_trig;
  logic        w_take;
  logic        w_drained;

  assign w_trig = wb_valid & (has_int | wb_excp | wb_ertn);
  assign w_take = (r_state == S_IDLE) & w_trig;

`ifdef EXCP_DRAIN_EN
  localparam logic [OUTS_W-1:0] OUTS_MAX = '1;

  logic [OUTS_W-1:0] r_outs;
  logic              w_inc;
  logic              w_dec;

  assign w_inc = mem_issue & ~mem_done & (r_outs != OUTS_MAX);
  assign w_dec = mem_done & ~mem_issue & (r_outs != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outs <= '0;
    end else if (w_inc) begin
      r_outs <= r_outs + OUTS_W'(1);
    end else if (w_dec) begin
      r_outs <= r_outs - OUTS_W'(1);
    end
  end

  assign w_drained    = (r_outs == '0);
  assign w_trig_state = S_DRAIN;
`else
  localparam int unused_outs_w = OUTS_W;

  logic w_unused_mem;

  assign w_unused_mem = mem_issue ^ mem_done;
  assign w_drained    = 1'b1;
  assign w_trig_state = S_COMMIT;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_trig) w_state_nxt = w_trig_state;
      S_DRAIN:    if (w_drained) w_state_nxt = S_COMMIT;
      S_COMMIT:   w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Interrupt outranks a synchronous exception, which outranks ERTN.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kind      <= K_INT;
      r_era       <= '0;
      r_code      <= '0;
      r_subcode   <= '0;
      r_tlbr      <= 1'b0;
      r_badv_flag <= 1'b0;
      r_badv      <= '0;
    end else if (w_take) begin
      r_era <= wb_pc;
      priority case (1'b1)
        has_int: begin
          r_kind      <= K_INT;
          r_code      <= '0;
          r_subcode   <= '0;
          r_tlbr      <= 1'b0;
          r_badv_flag <= 1'b0;
          r_badv      <= '0;
        end
        wb_excp: begin
          r_kind      <= K_EXC;
          r_code      <= wb_ecode;
          r_subcode   <= wb_esubcode;
          r_tlbr      <= wb_tlbr;
          r_badv_flag <= wb_badv_valid;
          r_badv      <= wb_badv;
        end
        default: begin
          r_kind      <= K_ERTN;
          r_code      <= '0;
          r_subcode   <= '0;
          r_tlbr      <= 1'b0;
          r_badv_flag <= 1'b0;
          r_badv      <= '0;
        end
      endcase
    end
  end

  always_comb begin
    csr_excp           = 1'b0;
    csr_excp_tlbrefill = 1'b0;
    csr_excpAboutAddr  = 1'b0;
    csr_ertn           = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    if (r_state == S_COMMIT) begin
      if (r_kind == K_ERTN) begin
        csr_ertn = 1'b1;
      end else begin
        csr_excp           = 1'b1;
        csr_excp_tlbrefill = r_tlbr;
        csr_excpAboutAddr  = r_badv_flag;
      end
    end
    // Entry CSRs are read a cycle after commit so they reflect the update.
    if (r_state == S_REDIRECT) begin
      redirect_valid = 1'b1;
      if (r_tlbr) begin
        redirect_pc = tlbrentry_in;
      end else if (r_kind == K_ERTN) begin
        redirect_pc = era_in;
      end else begin
        redirect_pc = eentry_in;
      end
    end
  end

  assign flush         = (r_state != S_IDLE);
  assign wb_ready      = (r_state == S_IDLE);
  assign csr_era       = r_era;
  assign csr_code      = r_code;
  assign csr_subcode   = r_subcode;
  assign csr_badv_addr = r_badv;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// tb_excp_commit_ctrl: vector table plus multi-cycle sequences with a
// scoreboard of expected commits popped when the commit pulse appears.
module tb_excp_commit_ctrl;

`ifdef EXCP_DRAIN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_excp, wb_tlbr, wb_badv_valid, wb_ertn;
  logic        has_int, mem_issue, mem_done;
  logic [31:0] wb_pc, wb_badv, eentry_in, tlbrentry_in, era_in;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        wb_ready, flush, csr_excp, csr_excp_tlbrefill, csr_ertn;
  logic [31:0] csr_era, csr_badv_addr, redirect_pc;
  logic [5:0]  csr_code;
  logic [8:0]  csr_subcode;
  logic        csr_excpAboutAddr, redirect_valid;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        v, i, x, t, r, bv;
    logic [5:0]  ec;
    logic [8:0]  sc;
    logic [31:0] badv, pc, een, tre, era;
    logic        trig, e_exc, e_tlb, e_ert, e_abt;
    logic [5:0]  e_code;
    logic [8:0]  e_sub;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vt [NV];
  vec_t sb [$];

  excp_commit_ctrl #(.OUTS_W(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc),
    .wb_excp(wb_excp), .wb_tlbr(wb_tlbr),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_badv_valid(wb_badv_valid), .wb_badv(wb_badv),
    .wb_ertn(wb_ertn), .has_int(has_int),
    .mem_issue(mem_issue), .mem_done(mem_done),
    .eentry_in(eentry_in), .tlbrentry_in(tlbrentry_in),
    .era_in(era_in),
    .wb_ready(wb_ready), .flush(flush),
    .csr_excp(csr_excp), .csr_excp_tlbrefill(csr_excp_tlbrefill),
    .csr_ertn(csr_ertn), .csr_era(csr_era),
    .csr_badv_addr(csr_badv_addr), .csr_code(csr_code),
    .csr_subcode(csr_subcode), .csr_excpAboutAddr(csr_excpAboutAddr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input logic v, i, x, t, r,
    input logic [5:0] ec, input logic [8:0] sc,
    input logic bv, input logic [31:0] badv, pc, een, tre, era,
    input logic trig, e_exc, e_tlb, e_ert, e_abt,
    input logic [5:0] e_code, input logic [8:0] e_sub,
    input logic [31:0] e_rpc);
    vec_t o;
    o.v = v; o.i = i; o.x = x; o.t = t; o.r = r;
    o.ec = ec; o.sc = sc; o.bv = bv; o.badv = badv;
    o.pc = pc; o.een = een; o.tre = tre; o.era = era;
    o.trig = trig; o.e_exc = e_exc; o.e_tlb = e_tlb;
    o.e_ert = e_ert; o.e_abt = e_abt;
    o.e_code = e_code; o.e_sub = e_sub; o.e_rpc = e_rpc;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    wb_valid = v.v; has_int = v.i; wb_excp = v.x;
    wb_tlbr = v.t; wb_ertn = v.r;
    wb_ecode = v.ec; wb_esubcode = v.sc;
    wb_badv_valid = v.bv; wb_badv = v.badv; wb_pc = v.pc;
    eentry_in = v.een; tlbrentry_in = v.tre; era_in = v.era;
  endtask

  task automatic clear_ev();
    wb_valid = 0; has_int = 0; wb_excp = 0;
    wb_tlbr = 0; wb_ertn = 0; wb_badv_valid = 0;
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("quiet_flush", flush, 0);
      chk("quiet_ready", wb_ready, 1);
      chk("quiet_pulse", {csr_excp, csr_ertn, redirect_valid}, 0);
      chk("quiet_rpc", redirect_pc, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_commit(input int lat);
    int   c;
    vec_t e;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (!(csr_excp | csr_ertn)) chk("wait_flush", flush, 1);
    end while (!(csr_excp | csr_ertn) && c < 40);
    if (!(csr_excp | csr_ertn)) begin
      n_cmp++; n_bad++;
      $display("FAIL commit_timeout: got none want pulse");
      if (sb.size() != 0) void'(sb.pop_front());
      @(posedge clk); #1;
      return;
    end
    chk("latency", c, lat);
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_commit: got pulse want none");
      @(posedge clk); #1;
      return;
    end
    e = sb.pop_front();
    chk("csr_excp", csr_excp, e.e_exc);
    chk("csr_tlbr", csr_excp_tlbrefill, e.e_tlb);
    chk("csr_ertn", csr_ertn, e.e_ert);
    chk("csr_about", csr_excpAboutAddr, e.e_abt);
    chk("csr_era", csr_era, e.pc);
    chk("commit_flush", flush, 1);
    if (e.e_exc) begin
      chk("csr_code", csr_code, e.e_code);
      chk("csr_sub", csr_subcode, e.e_sub);
    end
    if (e.e_abt) chk("csr_badv", csr_badv_addr, e.badv);
    @(negedge clk);
    chk("redir_valid", redirect_valid, 1);
    chk("redir_pc", redirect_pc, e.e_rpc);
    chk("redir_flush", flush, 1);
    chk("single_pulse", {csr_excp, csr_ertn}, 0);
    @(negedge clk);
    chk("back_ready", wb_ready, 1);
    chk("back_flush", flush, 0);
    chk("back_redir", redirect_valid, 0);
    chk("back_rpc", redirect_pc, 0);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    if (v.trig) sb.push_back(v);
    @(posedge clk); #1;
    clear_ev();
    if (v.trig) wait_commit(LAT);
    else quiet(4);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    clear_ev();
    wb_pc = 0; wb_badv = 0; wb_ecode = 0; wb_esubcode = 0;
    eentry_in = 0; tlbrentry_in = 0; era_in = 0;
    mem_issue = 0; mem_done = 0;

    //     v i x t r  ec     sc      bv badv          pc            eentry        tlbrentry     era_in
    vt[0] = mk(1,0,1,0,0, 6'hB,  9'h0,   0, 32'h0,        32'h1c000100, 32'h1c008000, 32'h1c00f000, 32'h0,
               1,1,0,0,0, 6'hB,  9'h0,   32'h1c008000);
    vt[1] = mk(1,1,0,0,1, 6'h0,  9'h0,   0, 32'h0,        32'h1c000200, 32'h1c008000, 32'h1c00f000, 32'h1c000999,
               1,1,0,0,0, 6'h0,  9'h0,   32'h1c008000);
    vt[2] = mk(1,0,0,0,1, 6'h0,  9'h0,   0, 32'h0,        32'h1c000300, 32'h1c008000, 32'h1c00f000, 32'h1c000204,
               1,0,0,1,0, 6'h0,  9'h0,   32'h1c000204);
    vt[3] = mk(1,0,1,1,0, 6'h3F, 9'h0,   1, 32'h00400010, 32'h1c000400, 32'h1c008000, 32'h1c00f000, 32'h0,
               1,1,1,0,1, 6'h3F, 9'h0,   32'h1c00f000);
    vt[4] = mk(1,0,1,0,0, 6'h8,  9'h1,   1, 32'hdeadbeec, 32'h1c000500, 32'h1c010000, 32'h1c00f000, 32'h0,
               1,1,0,0,1, 6'h8,  9'h1,   32'h1c010000);
    vt[5] = mk(0,0,1,0,0, 6'h5,  9'h0,   0, 32'h0,        32'h1c000600, 32'h1c008000, 32'h1c00f000, 32'h0,
               0,0,0,0,0, 6'h0,  9'h0,   32'h0);
    vt[6] = mk(1,1,1,1,0, 6'h5,  9'h3,   1, 32'h00001234, 32'h1c000700, 32'h1c020000, 32'h1c00f000, 32'h0,
               1,1,0,0,0, 6'h0,  9'h0,   32'h1c020000);
    vt[7] = mk(1,0,0,1,1, 6'h0,  9'h0,   0, 32'h0,        32'h1c000800, 32'h1c008000, 32'h1c00f000, 32'h1c000704,
               1,0,0,1,0, 6'h0,  9'h0,   32'h1c000704);
    vt[8] = mk(1,0,0,0,0, 6'h0,  9'h0,   0, 32'h0,        32'h1c000900, 32'h1c008000, 32'h1c00f000, 32'h0,
               0,0,0,0,0, 6'h0,  9'h0,   32'h0);
    vt[9] = mk(1,0,1,0,0, 6'h3F, 9'h1FF, 0, 32'h0,        32'h1c000a00, 32'h1c030000, 32'h1c00f000, 32'h0,
               1,1,0,0,0, 6'h3F, 9'h1FF, 32'h1c030000);

    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", wb_ready, 1);
    chk("rst_flush", flush, 0);
    chk("rst_pulses", {csr_excp, csr_excp_tlbrefill, csr_ertn, csr_excpAboutAddr}, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_era", csr_era, 0);
    chk("rst_code", csr_code, 0);
    chk("rst_sub", csr_subcode, 0);
    chk("rst_badv", csr_badv_addr, 0);
    @(posedge clk); #1;

    mem_done = 1;
    @(posedge clk); #1;
    mem_done = 0;

    for (int k = 0; k < NV; k++) run_vec(vt[k]);

`ifdef EXCP_DRAIN_EN
    repeat (3) begin
      mem_issue = 1;
      @(posedge clk); #1;
    end
    mem_issue = 0;
    drive(vt[0]);
    sb.push_back(vt[0]);
    @(posedge clk); #1;
    clear_ev();
    for (int k = 0; k < 3; k++) begin
      repeat (4) begin
        @(negedge clk);
        chk("drain_flush", flush, 1);
        chk("drain_quiet", {csr_excp, csr_ertn, redirect_valid}, 0);
        @(posedge clk); #1;
      end
      mem_done = 1;
      @(posedge clk); #1;
      mem_done = 0;
    end
    wait_commit(2);

    mem_issue = 1;
    @(posedge clk); #1;
    mem_done = 1;
    @(posedge clk); #1;
    mem_issue = 0; mem_done = 0;
    drive(vt[2]);
    sb.push_back(vt[2]);
    @(posedge clk); #1;
    clear_ev();
    repeat (4) begin
      @(negedge clk);
      chk("both_flush", flush, 1);
      chk("both_quiet", {csr_excp, csr_ertn, redirect_valid}, 0);
      @(posedge clk); #1;
    end
    mem_done = 1;
    @(posedge clk); #1;
    mem_done = 0;
    wait_commit(2);

    mem_issue = 1;
    @(posedge clk); #1;
    mem_issue = 0;
    drive(vt[4]);
    @(posedge clk); #1;
    clear_ev();
    @(negedge clk);
    chk("pre_rst_flush", flush, 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("mid_rst_ready", wb_ready, 1);
    chk("mid_rst_flush", flush, 0);
    @(posedge clk); #1;
    quiet(4);
    run_vec(vt[0]);
`else
    repeat (3) begin
      mem_issue = 1;
      @(posedge clk); #1;
    end
    mem_issue = 0;
    run_vec(vt[0]);
`endif

    drive(vt[1]);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    clear_ev();
    @(negedge clk);
    chk("trig_rst_ready", wb_ready, 1);
    chk("trig_rst_flush", flush, 0);
    @(posedge clk); #1;
    quiet(3);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
